// File: rtl/mau_reliable_send_seq_unit.sv
// mau_reliable_send_seq_unit: reliable-send action stage assigning per-flow RPNs,
// with an internal forwarding history so back-to-back same-flow updates stay coherent.
module mau_reliable_send_seq_unit #(
    parameter int PHV_WIDTH       = 456,
    parameter int PHV_B_COUNT     = 9,
    parameter int PHV_H_COUNT     = 2,
    parameter int PHV_W_COUNT     = 11,
    parameter int FLOWSTATE_WIDTH = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int FWD_DEPTH       = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       reliable_enable,
    input  logic [PHV_WIDTH-1:0]       s_phv_info,
    input  logic                       s_phv_valid,
    output logic                       s_phv_ready,
    input  logic                       s_phv_mat_hit,
    input  logic [FLOWSTATE_WIDTH-1:0] s_phv_mat_value,
    input  logic [ADDR_WIDTH-1:0]      s_phv_mat_addr,
    output logic [PHV_WIDTH-1:0]       m_phv_info,
    output logic                       m_phv_valid,
    input  logic                       m_phv_ready,
    output logic [FLOWSTATE_WIDTH-1:0] bcd_flowstate_out,
    output logic [ADDR_WIDTH-1:0]      bcd_addr_out,
    output logic                       bcd_valid_out,
    output logic [CNT_WIDTH-1:0]       stat_dat_hit,
    output logic [CNT_WIDTH-1:0]       stat_dat_miss
);
    // containers are packed bytes first, then halfwords, then words, from bit 0 upward
    localparam int HO      = 8 * PHV_B_COUNT;
    localparam int WO      = HO + 16 * PHV_H_COUNT;
    localparam int RPN_LSB = WO + 32 * 9;
    localparam int FI_LSB  = HO + 16;

    logic [PHV_WIDTH-1:0]       info_q, info_d;
    logic                       valid_q;
    logic [FWD_DEPTH-1:0]       hv_q;
    logic [ADDR_WIDTH-1:0]      ha_q [FWD_DEPTH];
    logic [FLOWSTATE_WIDTH-1:0] hf_q [FWD_DEPTH];
    logic [FLOWSTATE_WIDTH-1:0] fs, nfs, bcd_fs_q;
    logic [ADDR_WIDTH-1:0]      bcd_addr_q;
    logic                       bcd_valid_q;
    logic [CNT_WIDTH-1:0]       hit_cnt_q, miss_cnt_q;
    logic                       accept, act, dat, nack, dat_hit, dat_miss;

    assign s_phv_ready = ~valid_q | m_phv_ready;
    assign accept      = s_phv_valid & s_phv_ready;
    assign act         = reliable_enable & s_phv_info[15];
    assign dat         = s_phv_info[2];
    assign nack        = s_phv_info[3];
    assign dat_hit     = accept & act & s_phv_mat_hit & dat;
    assign dat_miss    = accept & act & ~s_phv_mat_hit & dat;
    assign nfs         = fs + 1'b1;

    // walk oldest to newest so the newest matching entry wins
    always_comb begin
        fs = s_phv_mat_value;
        for (int i = FWD_DEPTH - 1; i >= 0; i--)
            if (hv_q[i] && ha_q[i] == s_phv_mat_addr) fs = hf_q[i];
    end

    always_comb begin
        info_d = s_phv_info;
        if (act && s_phv_mat_hit && dat) begin
            info_d[5]                = 1'b0;
            info_d[11]               = 1'b1;
            info_d[12]               = 1'b0;
            info_d[RPN_LSB +: 32]    = 32'(fs);
            info_d[FI_LSB +: 16]     = 16'(s_phv_mat_addr);
        end else if (act && s_phv_mat_hit && nack) begin
            info_d[11]               = 1'b1;
            info_d[FI_LSB +: 16]     = 16'(s_phv_mat_addr);
        end else if (act && !s_phv_mat_hit && dat) begin
            info_d[5]                = 1'b1;
            info_d[12]               = 1'b1;
            info_d[40 +: 8]          = 8'd9;
            info_d[RPN_LSB +: 32]    = 32'd0;
        end else if (act && !s_phv_mat_hit) begin
            info_d[24 +: 8]          = 8'h7F;
            info_d[40 +: 8]          = 8'd15;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            hv_q        <= '0;
            bcd_valid_q <= 1'b0;
            bcd_addr_q  <= '0;
            bcd_fs_q    <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            valid_q     <= accept | (valid_q & ~m_phv_ready);
            bcd_valid_q <= dat_hit;
            if (dat_hit) begin
                for (int i = FWD_DEPTH - 1; i > 0; i--) hv_q[i] <= hv_q[i-1];
                hv_q[0]    <= 1'b1;
                bcd_addr_q <= s_phv_mat_addr;
                bcd_fs_q   <= nfs;
                hit_cnt_q  <= hit_cnt_q + CNT_WIDTH'(hit_cnt_q != '1);
            end
            if (dat_miss) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(miss_cnt_q != '1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) info_q <= info_d;
        if (dat_hit) begin
            for (int i = FWD_DEPTH - 1; i > 0; i--) begin
                ha_q[i] <= ha_q[i-1];
                hf_q[i] <= hf_q[i-1];
            end
            ha_q[0] <= s_phv_mat_addr;
            hf_q[0] <= nfs;
        end
    end

    assign m_phv_info        = info_q;
    assign m_phv_valid       = valid_q;
    assign bcd_valid_out     = bcd_valid_q;
    assign bcd_addr_out      = bcd_addr_q;
    assign bcd_flowstate_out = bcd_fs_q;
    assign stat_dat_hit      = hit_cnt_q;
    assign stat_dat_miss     = miss_cnt_q;
endmodule

// File: tb/tb_mau_reliable_send_seq_unit.sv
// tb_mau_reliable_send_seq_unit: directed stimulus, queue-based flow model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_mau_reliable_send_seq_unit;
    localparam int W     = 456;
    localparam int DEPTH = 2;
    localparam int HO    = 72;
    localparam int RPNL  = HO + 32 + 288;
    localparam int FIL   = HO + 16;

    logic clk = 0, rst_n = 0, rel_en = 1, s_valid = 0, hit = 0, m_ready = 1;
    logic [W-1:0] s_info = '0;
    logic [31:0] mval = '0;
    logic [9:0] maddr = '0;
    logic s_ready, m_valid, bcd_valid;
    logic [W-1:0] m_info;
    logic [31:0] bcd_fs;
    logic [9:0] bcd_addr;
    logic [15:0] st_hit, st_miss;

    int ncmp = 0, nfail = 0;

    mau_reliable_send_seq_unit #(.FWD_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .reliable_enable(rel_en),
        .s_phv_info(s_info), .s_phv_valid(s_valid), .s_phv_ready(s_ready),
        .s_phv_mat_hit(hit), .s_phv_mat_value(mval), .s_phv_mat_addr(maddr),
        .m_phv_info(m_info), .m_phv_valid(m_valid), .m_phv_ready(m_ready),
        .bcd_flowstate_out(bcd_fs), .bcd_addr_out(bcd_addr), .bcd_valid_out(bcd_valid),
        .stat_dat_hit(st_hit), .stat_dat_miss(st_miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gb(input logic [W-1:0] p, input int i);
        return p[8*i +: 8];
    endfunction

    // model: newest-first list of {addr, next flowstate} limited to DEPTH entries
    typedef struct { logic [9:0] a; logic [31:0] f; } ent_t;
    ent_t hist[$];
    logic [W-1:0] mo;
    logic mv = 0, mbv = 0;
    logic [9:0] mba = '0;
    logic [31:0] mbf = '0;
    logic [15:0] mh = '0, mm = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv = 0; mbv = 0; mba = '0; mbf = '0; mh = '0; mm = '0;
            hist.delete();
        end else begin
            logic acc;
            logic [31:0] f;
            logic [W-1:0] o;
            bit found;
            acc = s_valid && (!mv || m_ready);
            mbv = 0;
            if (acc) begin
                f = mval;
                found = 0;
                for (int i = 0; i < hist.size(); i++)
                    if (!found && hist[i].a == maddr) begin f = hist[i].f; found = 1; end
                o = s_info;
                if (rel_en && o[15]) begin
                    if (hit && o[2]) begin
                        o[5] = 0; o[11] = 1; o[12] = 0;
                        o[RPNL +: 32] = f;
                        o[FIL +: 16] = {6'd0, maddr};
                        hist.push_front('{maddr, f + 32'd1});
                        if (hist.size() > DEPTH) void'(hist.pop_back());
                        mbv = 1; mba = maddr; mbf = f + 32'd1;
                        if (mh != 16'hFFFF) mh++;
                    end else if (hit && o[3]) begin
                        o[11] = 1;
                        o[FIL +: 16] = {6'd0, maddr};
                    end else if (!hit && o[2]) begin
                        o[5] = 1; o[12] = 1; o[40 +: 8] = 8'd9; o[RPNL +: 32] = '0;
                        if (mm != 16'hFFFF) mm++;
                    end else if (!hit) begin
                        o[24 +: 8] = 8'h7F; o[40 +: 8] = 8'd15;
                    end
                end
                mo = o; mv = 1;
            end else if (m_ready) mv = 0;
        end
    end

    always @(negedge clk) begin
        chk("m_valid", W'(m_valid), W'(mv));
        chk("s_ready", W'(s_ready), W'(!mv || m_ready));
        if (mv) chk("m_info", m_info, mo);
        chk("bcd_valid", W'(bcd_valid), W'(mbv));
        chk("bcd_addr", W'(bcd_addr), W'(mba));
        chk("bcd_fs", W'(bcd_fs), W'(mbf));
        chk("stat_hit", W'(st_hit), W'(mh));
        chk("stat_miss", W'(st_miss), W'(mm));
    end

    function automatic logic [W-1:0] mk(input int seed, input bit d, input bit n, input bit send);
        logic [W-1:0] p;
        for (int i = 0; i < W / 32 + 1; i++) p[32*i +: 32] = 32'h9E37_79B9 * (seed + i + 1);
        p[2] = d; p[3] = n; p[15] = send;
        return p;
    endfunction

    task automatic step(input logic [W-1:0] p, input bit h, input logic [9:0] a, input logic [31:0] v);
        s_info = p; hit = h; maddr = a; mval = v; s_valid = 1;
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        s_valid = 0;
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_reset();
        s_valid = 0; rst_n = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        idle(1);
    endtask

    initial begin
        logic [W-1:0] p, held;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        chk("reset_m_valid", W'(m_valid), W'(0));
        chk("reset_bcd_valid", W'(bcd_valid), W'(0));
        chk("reset_stat", W'({st_hit, st_miss}), W'(0));

        step(mk(1, 1, 0, 1), 1, 10'd5, 32'd100);
        chk("t1_rpn", W'(m_info[RPNL +: 32]), W'(100));
        chk("t1_bufhit", W'(m_info[11]), W'(1));
        chk("t1_flowidx", W'(m_info[FIL +: 16]), W'(5));
        chk("t1_bcd", W'({bcd_valid, bcd_addr, bcd_fs}), W'({1'b1, 10'd5, 32'd101}));
        idle(1);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(mk(10 + i, 1, 0, 1), 1, 10'd5, 32'd100);
            chk("b2b_rpn", W'(m_info[RPNL +: 32]), W'(100 + i));
        end
        chk("b2b_bcd_fs", W'(bcd_fs), W'(106));
        chk("b2b_stat", W'(st_hit), W'(6));
        idle(1);

        do_reset();
        step(mk(20, 1, 0, 1), 1, 10'd1, 32'd0);
        step(mk(21, 1, 0, 1), 1, 10'd2, 32'd0);
        step(mk(22, 1, 0, 1), 1, 10'd3, 32'd0);
        step(mk(23, 1, 0, 1), 1, 10'd1, 32'd50);
        chk("aged_rpn", W'(m_info[RPNL +: 32]), W'(50));
        step(mk(24, 1, 0, 1), 1, 10'd3, 32'd77);
        chk("fwd_rpn", W'(m_info[RPNL +: 32]), W'(1));

        step(mk(25, 1, 0, 1), 1, 10'd9, 32'hFFFF_FFFF);
        chk("wrap_rpn", W'(m_info[RPNL +: 32]), W'(32'hFFFF_FFFF));
        chk("wrap_bcd_fs", W'(bcd_fs), W'(0));

        step(mk(26, 1, 0, 1), 0, 10'd4, 32'd3);
        chk("miss_rst", W'(m_info[5]), W'(1));
        chk("miss_tid", W'(gb(m_info, 5)), W'(9));
        chk("miss_rpn", W'(m_info[RPNL +: 32]), W'(0));
        chk("miss_clone", W'(m_info[12]), W'(1));
        chk("miss_no_bcd", W'(bcd_valid), W'(0));
        step(mk(27, 0, 0, 1), 0, 10'd4, 32'd3);
        chk("ndmiss_outport", W'(gb(m_info, 3)), W'(8'h7F));
        chk("ndmiss_tid", W'(gb(m_info, 5)), W'(15));
        step(mk(28, 0, 1, 1), 1, 10'd33, 32'd3);
        chk("nack_flowidx", W'(m_info[FIL +: 16]), W'(33));
        chk("nack_no_bcd", W'(bcd_valid), W'(0));
        p = mk(29, 0, 0, 1);
        step(p, 1, 10'd7, 32'd3);
        chk("other_hit", m_info, p);
        p = mk(30, 1, 1, 0);
        step(p, 1, 10'd7, 32'd3);
        chk("no_send_tbl", m_info, p);
        idle(1);

        m_ready = 0;
        step(mk(31, 1, 0, 1), 1, 10'd8, 32'd40);
        held = m_info;
        s_info = mk(32, 1, 0, 1); mval = 32'd60;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("hold_ready", W'(s_ready), W'(0));
            chk("hold_info", m_info, held);
        end
        m_ready = 1;
        @(posedge clk); #2;
        chk("hold_release_rpn", W'(m_info[RPNL +: 32]), W'(41));

        rel_en = 0;
        p = mk(33, 1, 0, 1);
        step(p, 1, 10'd8, 32'd1);
        chk("disabled_pass", m_info, p);
        rel_en = 1;

        step(mk(34, 1, 0, 1), 1, 10'd5, 32'd200);
        step(mk(35, 1, 0, 1), 1, 10'd5, 32'd200);
        #1 rst_n = 0;
        #1 chk("midreset_valid", W'(m_valid), W'(0));
        @(posedge clk); #2 rst_n = 1;
        step(mk(36, 1, 0, 1), 1, 10'd5, 32'd7);
        chk("post_reset_rpn", W'(m_info[RPNL +: 32]), W'(7));
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
